bz_packet_deserializer: RTL and testbench
=========================================

Name: bz_packet_deserializer

Overview:
- Pops W_FLIT+1-bit flits (payload plus tail bit) from a show-ahead router FIFO and concatenates them, MSB-first, into one NCODE+NDATA-bit word.
- Emits that word on a four-phase valid/ack channel toward the PC-side output.
- Generalised successor of the fixed BZ deserializer: variable-length packets of 1..MAX_FLITS flits, reported flit count, over-length packet discard with a saturating error counter, and full back-pressure.

Parameters:
- NCODE, 8, route/code field width (upper bits of output word)
- NDATA, 24, data field width; NOUT = NCODE+NDATA = 32
- W_FLIT, 10, payload bits per flit; data_in width is W_FLIT+1
- MAX_FLITS, 4, maximum flits per packet; MAX_FLITS*W_FLIT >= NOUT required
- ERR_W, 8, error counter width

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- data_in  in  W_FLIT+1  FIFO head flit; bit W_FLIT = tail, [W_FLIT-1:0] = payload; valid whenever isempty=0
- isempty  in  1  FIFO empty
- rdreq  out  1  pop FIFO head at this rising edge
- out_v  out  1  output word valid
- out_a  in  1  output acknowledge
- out_d  out  NOUT  assembled word
- out_nflits  out  $clog2(MAX_FLITS+1)  flits in packet carried by out_d
- err_count  out  ERR_W  count of dropped over-length packets, saturating

Behaviour:
- Reset (reset=0, async): state=ACCUM; acc=0; cnt=0; out_v=0; out_d=0; out_nflits=0; err_count=0. rdreq is forced to 0 while reset=0.
- rdreq is combinational: rdreq = reset & ~isempty & (state==ACCUM | state==DROP). A flit is consumed exactly at each edge where rdreq=1.
- ACCUM, on a pop, with acc a MAX_FLITS*W_FLIT-bit shift register and cnt the flits held:
  - tail=1: out_d <= {acc,payload}[NOUT-1:0]; out_nflits <= cnt+1; out_v <= 1; acc, cnt <= 0; go to SEND. Short packets are right-aligned and zero-extended. Bits of the first flit above NOUT are discarded.
  - tail=0 and cnt+1==MAX_FLITS: over-length. acc, cnt <= 0; err_count++ unless at all-ones; go to DROP.
  - tail=0 otherwise: acc <= {acc,payload}; cnt++.
- DROP: pop and discard flits until a tail flit is popped, then go to ACCUM. No out_v is produced for a dropped packet.
- SEND: out_v=1; out_d and out_nflits held stable; no pops. At the first edge with out_a=1: out_v <= 0; go to WAITLOW.
- WAITLOW: no pops. At the first edge with out_a=0: go to ACCUM.
- out_v never rises while out_a=1.
- Latency: tail pop at edge k gives out_v=1 after edge k. Minimum packet spacing is 1 pop + 2 handshake edges.
- Empty FIFO (isempty=1) mid-packet: no pop; acc and cnt retained indefinitely.
- Reset mid-packet or mid-handshake: partial packet lost; out_v drops immediately. The next packet carries no stale bits.
- Flits are never duplicated or reordered. Every popped flit belongs to exactly one output word or one dropped packet.

Test Plan:
- Four-flit packet, data_in = 0x001, 0x002, 0x003, 0x7FF (tail, payload 0x3FF); out_a = registered out_v -> one transfer with out_d=0x40200FFF, out_nflits=4, err_count=0.
- Single-flit packet 0x555 (tail, payload 0x155) -> out_d=0x00000155, out_nflits=1. Out_v rises the cycle after the pop and falls the cycle after out_a rises.
- Four non-tail flits 0x00A, 0x00B, 0x00C, 0x00D, then 0x00E, 0x40F, then single-flit 0x401 -> no output for the first packet; err_count=1. The next output is out_d=0x00000001, out_nflits=1. Repeat 300 times -> err_count saturates at 0xFF.
- Back-pressure: hold out_a=0 for 10 cycles after out_v with FIFO non-empty -> out_v, out_d, out_nflits stable and rdreq=0 throughout. After out_a pulses high then low, the next packet is assembled correctly.
- Empty gaps: isempty=1 for 5 cycles between flits 2 and 3 of a 3-flit packet 0x001, 0x002, 0x403 -> rdreq=0 during the gap; out_d=0x00100803, out_nflits=3.
- Reset mid-packet: pop 0x3FF, 0x3FF, assert reset for 2 cycles, then send 0x401 -> rdreq=0 during reset; out_d=0x00000001, out_nflits=1.

Source files
------------

// File: rtl/bz_packet_deserializer.sv
// ============================================================================
// bz_packet_deserializer
//   Packs 1..MAX_FLITS flits from a show-ahead FIFO into one NOUT-bit word
//   and hands it off over a four-phase valid/ack channel.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module bz_packet_deserializer #(
    parameter  int NCODE     = 8,
    parameter  int NDATA     = 24,
    parameter  int W_FLIT    = 10,
    parameter  int MAX_FLITS = 4,
    parameter  int ERR_W     = 8,
    localparam int NOUT      = NCODE + NDATA,
    localparam int CNT_W     = $clog2(MAX_FLITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W_FLIT:0]   data_in,
    input  logic              isempty,
    output logic              rdreq,
    output logic              out_v,
    input  logic              out_a,
    output logic [NOUT-1:0]   out_d,
    output logic [CNT_W-1:0]  out_nflits,
    output logic [ERR_W-1:0]  err_count
);

    // Only the low NOUT-W_FLIT bits of earlier flits can ever reach out_d, so the
    // accumulator keeps just those; anything above NOUT is discarded on entry.
    localparam int               c_KEEP    = NOUT - W_FLIT;
    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_FLITS);

    typedef enum logic [1:0] {
        S_ACCUM   = 2'd0,
        S_DROP    = 2'd1,
        S_SEND    = 2'd2,
        S_WAITLOW = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_KEEP-1:0]  r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_tail;
    logic [W_FLIT-1:0]  w_payload;
    logic [NOUT-1:0]    w_cat;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_pop;
    logic               w_err_sat;

    assign w_tail    = data_in[W_FLIT];
    assign w_payload = data_in[W_FLIT-1:0];
    assign w_cat     = {r_acc, w_payload};
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_err_sat = &err_count;
    assign w_pop     = reset & ~isempty & ((r_state == S_ACCUM) | (r_state == S_DROP));
    assign rdreq     = w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_ACCUM;
            r_acc      <= '0;
            r_cnt      <= '0;
            out_v      <= 1'b0;
            out_d      <= '0;
            out_nflits <= '0;
            err_count  <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_pop) begin
                        if (w_tail) begin
                            out_d      <= w_cat;
                            out_nflits <= w_cnt_inc;
                            out_v      <= 1'b1;
                            r_acc      <= '0;
                            r_cnt      <= '0;
                            r_state    <= S_SEND;
                        end else if (w_cnt_inc == c_MAX_CNT) begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            if (!w_err_sat) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            r_state <= S_DROP;
                        end else begin
                            r_acc <= w_cat[c_KEEP-1:0];
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_DROP: begin
                    if (w_pop && w_tail) begin
                        r_state <= S_ACCUM;
                    end
                end
                S_SEND: begin
                    if (out_a) begin
                        out_v   <= 1'b0;
                        r_state <= S_WAITLOW;
                    end
                end
                S_WAITLOW: begin
                    // Return-to-zero phase: the next word may not be offered yet.
                    if (!out_a) begin
                        r_state <= S_ACCUM;
                    end
                end
                default: begin
                    r_state <= S_ACCUM;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bz_packet_deserializer.sv
// ============================================================================
// tb_bz_packet_deserializer
//   Randomized and directed bench with a packet-level reference model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bz_packet_deserializer;

    localparam int NCODE     = 8;
    localparam int NDATA     = 24;
    localparam int W_FLIT    = 10;
    localparam int MAX_FLITS = 4;
    localparam int ERR_W     = 8;
    localparam int NOUT      = NCODE + NDATA;
    localparam int CNT_W     = $clog2(MAX_FLITS + 1);
    localparam int ERR_MAX   = (1 << ERR_W) - 1;

    typedef logic [W_FLIT:0]   flit_t;
    typedef logic [W_FLIT-1:0] pay_t;

    logic              clk = 1'b0;
    logic              reset;
    flit_t             data_in;
    logic              isempty;
    logic              rdreq;
    logic              out_v;
    logic              out_a;
    logic [NOUT-1:0]   out_d;
    logic [CNT_W-1:0]  out_nflits;
    logic [ERR_W-1:0]  err_count;

    always #5 clk = ~clk;

    bz_packet_deserializer #(
        .NCODE(NCODE), .NDATA(NDATA), .W_FLIT(W_FLIT),
        .MAX_FLITS(MAX_FLITS), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .isempty(isempty),
        .rdreq(rdreq), .out_v(out_v), .out_a(out_a), .out_d(out_d),
        .out_nflits(out_nflits), .err_count(err_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    flit_t           fifo[$];
    int unsigned     pkt[$];
    int              m_err = 0;
    bit              m_out_v = 0;
    bit              m_waitlow = 0;
    logic [NOUT-1:0] m_word = '0;
    int              m_nflits = 0;

    bit rst_drive   = 0;
    bit force_gap   = 0;
    bit ack_hold    = 0;
    int gap_pct     = 0;
    bit pop_at_edge = 0;
    bit ack_at_edge = 0;
    bit prev_v      = 0;

    logic [NOUT-1:0] got_d[$];
    int              got_n[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int budget);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles", name, budget);
    endtask

    function automatic void model_clear();
        pkt.delete();
        m_out_v   = 0;
        m_waitlow = 0;
        m_err     = 0;
    endfunction

    // Packet-level rule: a packet of n flits becomes the concatenation of its
    // payloads (truncated to NOUT) if n <= MAX_FLITS, otherwise it is dropped
    // and counted once it is known to exceed MAX_FLITS.
    function automatic void model_pop(input flit_t f);
        logic [63:0] w;
        pkt.push_back(int'(f[W_FLIT-1:0]));
        if (f[W_FLIT]) begin
            if (pkt.size() <= MAX_FLITS) begin
                w = '0;
                foreach (pkt[i]) w = (w << W_FLIT) | 64'(pkt[i]);
                m_word   = w[NOUT-1:0];
                m_nflits = pkt.size();
                m_out_v  = 1;
            end
            pkt.delete();
        end else if (pkt.size() == MAX_FLITS) begin
            if (m_err < ERR_MAX) m_err++;
        end
    endfunction

    task automatic step();
        @(negedge clk);
        if (reset) begin
            if (m_out_v && ack_at_edge) begin
                m_out_v   = 0;
                m_waitlow = 1;
            end else if (m_waitlow && !ack_at_edge) begin
                m_waitlow = 0;
            end
            if (pop_at_edge && fifo.size() > 0) model_pop(fifo.pop_front());
        end

        check("out_v", 64'(out_v), 64'(m_out_v));
        if (m_out_v) begin
            check("out_d", 64'(out_d), 64'(m_word));
            check("out_nflits", 64'(out_nflits), 64'(m_nflits));
        end else if (!reset) begin
            check("out_d_in_reset", 64'(out_d), 64'(0));
        end
        check("err_count", 64'(err_count), 64'(m_err));
        if (out_v && !prev_v) begin
            got_d.push_back(out_d);
            got_n.push_back(int'(out_nflits));
        end
        prev_v = out_v;

        reset = rst_drive;
        if (!rst_drive) model_clear();
        isempty = (fifo.size() == 0) || force_gap || ($urandom_range(0, 99) < gap_pct);
        data_in = (fifo.size() > 0) ? fifo[0] : flit_t'($urandom);
        if (m_out_v) begin
            if (!out_a && !ack_hold && $urandom_range(0, 2) == 0) out_a = 1'b1;
        end else if (m_waitlow) begin
            if (out_a && $urandom_range(0, 2) == 0) out_a = 1'b0;
        end else begin
            out_a = 1'b0;
        end
        #1;
        check("rdreq", 64'(rdreq), 64'(rst_drive && !isempty && !m_out_v && !m_waitlow));
        pop_at_edge = rdreq && !isempty;
        ack_at_edge = out_a;
    endtask

    task automatic run_until_word(input string name, input int budget);
        int start = got_d.size();
        int k = 0;
        while (got_d.size() == start && k < budget) begin
            step();
            k++;
        end
        if (got_d.size() == start) begin
            timeout(name, budget);
            got_d.push_back('x);
            got_n.push_back(-1);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((fifo.size() > 0 || m_out_v || m_waitlow) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) timeout(name, budget);
    endtask

    task automatic push(input flit_t f);
        fifo.push_back(f);
    endtask

    initial begin
        int words_before;
        int exp_words;
        int k;

        reset = 1'b0;
        out_a = 1'b0;
        isempty = 1'b1;
        data_in = '0;
        rst_drive = 0;
        repeat (3) step();
        check("reset_out_v", 64'(out_v), 64'(0));
        check("reset_out_d", 64'(out_d), 64'(0));
        check("reset_nflits", 64'(out_nflits), 64'(0));
        check("reset_err", 64'(err_count), 64'(0));

        // Four-flit packet; FIFO already non-empty while still in reset
        push(11'h001); push(11'h002); push(11'h003); push(11'h7FF);
        repeat (2) step();
        check("reset_rdreq", 64'(rdreq), 64'(0));
        rst_drive = 1;
        run_until_word("four_flit", 50);
        check("four_flit_d", 64'(got_d[$]), 64'h4020_0FFF);
        check("four_flit_n", 64'(got_n[$]), 64'd4);
        check("four_flit_err", 64'(err_count), 64'(0));
        wait_idle("four_flit_idle", 50);

        push(11'h555);
        run_until_word("single", 50);
        check("single_d", 64'(got_d[$]), 64'h0000_0155);
        check("single_n", 64'(got_n[$]), 64'd1);
        wait_idle("single_idle", 50);

        // Over-length packet followed by a good one
        push(11'h00A); push(11'h00B); push(11'h00C); push(11'h00D);
        push(11'h00E); push(11'h40F); push(11'h401);
        run_until_word("overlen", 80);
        check("overlen_err", 64'(err_count), 64'd1);
        check("overlen_d", 64'(got_d[$]), 64'h0000_0001);
        check("overlen_n", 64'(got_n[$]), 64'd1);
        wait_idle("overlen_idle", 50);

        words_before = got_d.size();
        for (int i = 0; i < 299; i++) begin
            push(11'h00A); push(11'h00B); push(11'h00C); push(11'h00D);
            push(11'h00E); push(11'h40F); push(11'h401);
        end
        wait_idle("saturate", 20000);
        check("saturate_err", 64'(err_count), 64'hFF);
        check("saturate_words", 64'(got_d.size() - words_before), 64'd299);

        // Back-pressure with the FIFO still holding the next packet
        ack_hold = 1;
        push(11'h412); push(11'h401);
        run_until_word("bp", 50);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_out_v", 64'(out_v), 64'(1));
            check("bp_out_d", 64'(out_d), 64'h0000_0012);
            check("bp_nflits", 64'(out_nflits), 64'd1);
            check("bp_rdreq", 64'(rdreq), 64'(0));
        end
        ack_hold = 0;
        run_until_word("bp_next", 50);
        check("bp_next_d", 64'(got_d[$]), 64'h0000_0001);
        wait_idle("bp_idle", 50);

        // Empty gap between flits 2 and 3
        push(11'h001); push(11'h002);
        k = 0;
        while (fifo.size() > 0 && k < 30) begin step(); k++; end
        if (fifo.size() > 0) timeout("gap_fill", 30);
        force_gap = 1;
        push(11'h403);
        for (int i = 0; i < 5; i++) begin
            step();
            check("gap_rdreq", 64'(rdreq), 64'(0));
        end
        force_gap = 0;
        run_until_word("gap", 50);
        check("gap_d", 64'(got_d[$]), 64'h0010_0803);
        check("gap_n", 64'(got_n[$]), 64'd3);
        wait_idle("gap_idle", 50);

        // Reset in the middle of a packet
        push(11'h3FF); push(11'h3FF);
        k = 0;
        while (fifo.size() > 0 && k < 30) begin step(); k++; end
        if (fifo.size() > 0) timeout("rst_fill", 30);
        push(11'h401);
        rst_drive = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_rdreq", 64'(rdreq), 64'(0));
        end
        rst_drive = 1;
        run_until_word("rst_mid", 50);
        check("rst_mid_d", 64'(got_d[$]), 64'h0000_0001);
        check("rst_mid_n", 64'(got_n[$]), 64'd1);
        wait_idle("rst_idle", 50);

        // Randomized packets of 1..6 flits with random FIFO gaps
        gap_pct = 25;
        exp_words = 0;
        words_before = got_d.size();
        for (int p = 0; p < 150; p++) begin
            int len = int'($urandom_range(1, 6));
            if (len <= MAX_FLITS) exp_words++;
            for (int f = 0; f < len; f++) begin
                flit_t fl;
                fl[W_FLIT-1:0] = pay_t'($urandom);
                fl[W_FLIT]     = (f == len - 1);
                push(fl);
            end
        end
        wait_idle("random", 20000);
        check("random_words", 64'(got_d.size() - words_before), 64'(exp_words));
        gap_pct = 0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
